// File: rtl/reorder_pkg.sv
// Shared definitions for the reorder ID manager: FSM states and the ID-width helper.
package reorder_pkg;

  typedef enum logic [1:0] {
    StateInit = 2'd0,
    StateRun  = 2'd1,
    StateHalt = 2'd2
  } state_e;

  // Width needed to index DEPTH entries; never narrower than one bit.
  function automatic int id_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/reorder_id_fifo.sv
// Small first-word-fall-through FIFO used for both the free list and the
// allocation-order queue. Pointers wrap naturally because DEPTH is a power of two.
module reorder_id_fifo
  import reorder_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pull,
  output logic [WIDTH-1:0]           head_data,
  output logic                       valid,
  output logic                       full,
  output logic [id_width(DEPTH):0]   count
);

  localparam int AW = id_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pull;

  assign valid     = (count_reg != '0);
  assign full      = (count_reg == (AW+1)'(DEPTH));
  assign do_push   = push & ~full;
  assign do_pull   = pull & valid;
  // An empty FIFO presents zero so the offered ID is clean after reset.
  assign head_data = valid ? mem[rd_ptr_reg] : '0;
  assign count     = count_reg;

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pull) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pull};
    end
  end

endmodule

// File: rtl/reorder_id_manager.sv
// Trace-ID lifecycle manager: hands out free IDs in order, checks committed IDs
// against allocation order and returns them to the free pool.
module reorder_id_manager
  import reorder_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int ID_WIDTH = id_width(DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                reorder_full_i,
  output logic                alloc_valid_o,
  output logic [ID_WIDTH-1:0] alloc_id_o,
  input  logic                alloc_req_i,
  output logic                trace_id_push_o,
  output logic [ID_WIDTH-1:0] trace_id_value_o,
  input  logic                commit_id_valid_i,
  input  logic [ID_WIDTH-1:0] commit_id_value_i,
  output logic                commit_id_pull_o,
  output logic                retire_valid_o,
  output logic [ID_WIDTH-1:0] retire_id_o,
  output logic [ID_WIDTH:0]   inflight_cnt_o,
  output logic                error_o
);

  state_e              state_reg;
  logic [ID_WIDTH-1:0] init_cnt_reg;
  logic [DEPTH-1:0]    alloc_bits_reg;
  logic [DEPTH-1:0]    alloc_bits_next;
  logic                trace_push_reg;
  logic [ID_WIDTH-1:0] trace_value_reg;
  logic                retire_valid_reg;
  logic [ID_WIDTH-1:0] retire_id_reg;
  logic [ID_WIDTH:0]   inflight_reg;
  logic                error_reg;

  logic                free_push, free_pull, free_valid, free_full;
  logic [ID_WIDTH-1:0] free_push_data, free_head;
  logic [ID_WIDTH:0]   free_count;
  logic                order_push, order_pull, order_valid, order_full;
  logic [ID_WIDTH-1:0] order_head;
  logic [ID_WIDTH:0]   order_count;
  logic                unused_counts;

  logic in_init, in_run, alloc_fire, check_ok, retire_ok, check_err;

  assign in_init   = (state_reg == StateInit);
  assign in_run    = (state_reg == StateRun);

  assign alloc_valid_o    = in_run & free_valid & ~reorder_full_i;
  assign alloc_id_o       = free_head;
  assign alloc_fire       = alloc_valid_o & alloc_req_i;
  assign commit_id_pull_o = in_run & commit_id_valid_i;

  // A commit is legal only if it is the oldest outstanding ID and still marked allocated.
  assign check_ok  = order_valid & (commit_id_value_i == order_head)
                   & alloc_bits_reg[commit_id_value_i];
  assign retire_ok = commit_id_pull_o & check_ok;
  assign check_err = commit_id_pull_o & ~check_ok;

  // Retired IDs go to the free-list tail, so they are never offered in the same cycle.
  assign free_push      = (in_init | retire_ok) & ~free_full;
  assign free_push_data = in_init ? init_cnt_reg : commit_id_value_i;
  assign free_pull      = alloc_fire;
  assign order_push     = alloc_fire & ~order_full;
  assign order_pull     = retire_ok;
  assign unused_counts  = ^{free_count, order_count};

  reorder_id_fifo #(.DEPTH(DEPTH), .WIDTH(ID_WIDTH)) u_free_list (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (free_push),
    .push_data (free_push_data),
    .pull      (free_pull),
    .head_data (free_head),
    .valid     (free_valid),
    .full      (free_full),
    .count     (free_count)
  );

  reorder_id_fifo #(.DEPTH(DEPTH), .WIDTH(ID_WIDTH)) u_order_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (order_push),
    .push_data (free_head),
    .pull      (order_pull),
    .head_data (order_head),
    .valid     (order_valid),
    .full      (order_full),
    .count     (order_count)
  );

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_alloc_bit
      // Allocated and freed IDs always differ, so set and clear never collide.
      assign alloc_bits_next[gi] =
          (alloc_fire && free_head == ID_WIDTH'(gi)) ? 1'b1 :
          (retire_ok && commit_id_value_i == ID_WIDTH'(gi)) ? 1'b0 :
          alloc_bits_reg[gi];
    end
  endgenerate

  // Allocated-ID bitmap register.
  always_ff @(posedge clk_i) begin
    if (rst_i) alloc_bits_reg <= '0;
    else       alloc_bits_reg <= alloc_bits_next;
  end

  // Lifecycle FSM: seed the free list, run, then halt on any protocol error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= StateInit;
      init_cnt_reg <= '0;
      error_reg    <= 1'b0;
    end else begin
      case (state_reg)
        StateInit: begin
          init_cnt_reg <= init_cnt_reg + 1'b1;
          if (init_cnt_reg == ID_WIDTH'(DEPTH - 1)) state_reg <= StateRun;
        end
        StateRun: begin
          if (check_err) begin
            state_reg <= StateHalt;
            error_reg <= 1'b1;
          end
        end
        StateHalt: error_reg <= 1'b1;
        default:   state_reg <= StateHalt;
      endcase
    end
  end

  // Registered event outputs and in-flight counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trace_push_reg   <= 1'b0;
      trace_value_reg  <= '0;
      retire_valid_reg <= 1'b0;
      retire_id_reg    <= '0;
      inflight_reg     <= '0;
    end else begin
      trace_push_reg   <= alloc_fire;
      retire_valid_reg <= retire_ok;
      if (alloc_fire) trace_value_reg <= free_head;
      if (retire_ok)  retire_id_reg   <= commit_id_value_i;
      inflight_reg <= inflight_reg + {{ID_WIDTH{1'b0}}, alloc_fire}
                                   - {{ID_WIDTH{1'b0}}, retire_ok};
    end
  end

  assign trace_id_push_o  = trace_push_reg;
  assign trace_id_value_o = trace_value_reg;
  assign retire_valid_o   = retire_valid_reg;
  assign retire_id_o      = retire_id_reg;
  assign inflight_cnt_o   = inflight_reg;
  assign error_o          = error_reg;

endmodule

// File: tb/tb_reorder_id_manager.sv
// Bench for reorder_id_manager: directed vector table, a hand-written reset
// sequence, then random traffic against a queue-based reference model.
module tb_reorder_id_manager;

  localparam int DEPTH = 8;
  localparam int IW    = 3;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          reorder_full_i = 1'b0;
  logic          alloc_req_i = 1'b0;
  logic          commit_id_valid_i = 1'b0;
  logic [IW-1:0] commit_id_value_i = '0;
  logic          alloc_valid_o, trace_id_push_o, commit_id_pull_o, retire_valid_o, error_o;
  logic [IW-1:0] alloc_id_o, trace_id_value_o, retire_id_o;
  logic [IW:0]   inflight_cnt_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  reorder_id_manager #(.DEPTH(DEPTH)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .reorder_full_i    (reorder_full_i),
    .alloc_valid_o     (alloc_valid_o),
    .alloc_id_o        (alloc_id_o),
    .alloc_req_i       (alloc_req_i),
    .trace_id_push_o   (trace_id_push_o),
    .trace_id_value_o  (trace_id_value_o),
    .commit_id_valid_i (commit_id_valid_i),
    .commit_id_value_i (commit_id_value_i),
    .commit_id_pull_o  (commit_id_pull_o),
    .retire_valid_o    (retire_valid_o),
    .retire_id_o       (retire_id_o),
    .inflight_cnt_o    (inflight_cnt_o),
    .error_o           (error_o)
  );

  typedef struct {
    bit rst, full, req, cv; int cval; bit chk;
    bit av; int aid; bit pull; bit tp; int tv; bit rv; int rid; int inf; bit err;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit f, input bit q, input bit cv, input int cval);
    rst_i             = r;
    reorder_full_i    = f;
    alloc_req_i       = q;
    commit_id_valid_i = cv;
    commit_id_value_i = IW'(cval);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic void add(bit rst, bit full, bit req, bit cv, int cval, bit chk_en,
                              bit av, int aid, bit pull, bit tp, int tv, bit rv, int rid,
                              int inf, bit err);
    vec_t v;
    v.rst = rst; v.full = full; v.req = req; v.cv = cv; v.cval = cval; v.chk = chk_en;
    v.av = av; v.aid = aid; v.pull = pull; v.tp = tp; v.tv = tv; v.rv = rv; v.rid = rid;
    v.inf = inf; v.err = err;
    vecs.push_back(v);
  endfunction

  function automatic void row(bit full, bit req, bit cv, int cval, bit av, int aid, bit pull,
                              bit tp, int tv, bit rv, int rid, int inf, bit err);
    add(0, full, req, cv, cval, 1, av, aid, pull, tp, tv, rv, rid, inf, err);
  endfunction

  // Reset, then DEPTH init cycles with requests and commits held high: nothing may happen.
  function automatic void reset_init();
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < DEPTH; c++) row(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  // Reference model state.
  int free_q[$];
  int order_q[$];
  int init_left;
  bit halted, m_tp, m_rv, m_err;
  int m_tv, m_rid;

  function automatic void model_reset();
    free_q.delete();
    order_q.delete();
    init_left = DEPTH;
    halted = 0; m_tp = 0; m_rv = 0; m_err = 0; m_tv = 0; m_rid = 0;
  endfunction

  initial begin
    // Grant sequence after reset, then no same-cycle bypass of a retired ID.
    reset_init();
    for (int k = 0; k < DEPTH; k++) row(0, 1, 0, 0, 1, k, 0, k > 0, k - 1, 0, 0, k, 0);
    row(0, 1, 0, 0, 0, 0, 0, 1, 7, 0, 0, 8, 0);
    row(0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 8, 0);
    row(0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 7, 0);
    row(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 8, 0);
    // Allocate 0..2, commit 0..2, then the free list wraps 3..7,0,1,2.
    reset_init();
    row(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    row(0, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 1, 0);
    row(0, 1, 0, 0, 1, 2, 0, 1, 1, 0, 0, 2, 0);
    row(0, 0, 1, 0, 1, 3, 1, 1, 2, 0, 0, 3, 0);
    row(0, 0, 1, 1, 1, 3, 1, 0, 0, 1, 0, 2, 0);
    row(0, 0, 1, 2, 1, 3, 1, 0, 0, 1, 1, 1, 0);
    row(0, 0, 0, 0, 1, 3, 0, 0, 0, 1, 2, 0, 0);
    for (int j = 0; j < DEPTH; j++)
      row(0, 1, 0, 0, 1, (3 + j) % 8, 0, j > 0, (3 + j + 7) % 8, 0, 0, j, 0);
    row(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 8, 0);
    // Simultaneous alloc and retire at inflight 4.
    reset_init();
    for (int k = 0; k < 4; k++) row(0, 1, 0, 0, 1, k, 0, k > 0, k - 1, 0, 0, k, 0);
    row(0, 0, 0, 0, 1, 4, 0, 1, 3, 0, 0, 4, 0);
    row(0, 1, 1, 0, 1, 4, 1, 0, 0, 0, 0, 4, 0);
    row(0, 0, 0, 0, 1, 5, 0, 1, 4, 1, 0, 4, 0);
    row(0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 4, 0);
    // Out-of-order commit halts the block.
    reset_init();
    for (int k = 0; k < 3; k++) row(0, 1, 0, 0, 1, k, 0, k > 0, k - 1, 0, 0, k, 0);
    row(0, 0, 1, 2, 1, 3, 1, 1, 2, 0, 0, 3, 0);
    row(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1);
    row(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1);
    // reorder_full_i blocks grants with 6 IDs free.
    reset_init();
    for (int k = 0; k < 2; k++) row(0, 1, 0, 0, 1, k, 0, k > 0, k - 1, 0, 0, k, 0);
    row(1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2, 0);
    row(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0);
    row(0, 1, 0, 0, 1, 2, 0, 0, 0, 0, 0, 2, 0);
    row(0, 0, 0, 0, 1, 3, 0, 1, 2, 0, 0, 3, 0);

    step();
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].full, vecs[i].req, vecs[i].cv, vecs[i].cval);
      #1;
      if (vecs[i].chk) begin
        chk($sformatf("v%0d alloc_valid", i), alloc_valid_o, vecs[i].av);
        if (vecs[i].av) chk($sformatf("v%0d alloc_id", i), alloc_id_o, vecs[i].aid);
        chk($sformatf("v%0d pull", i), commit_id_pull_o, vecs[i].pull);
        chk($sformatf("v%0d trace_push", i), trace_id_push_o, vecs[i].tp);
        if (vecs[i].tp) chk($sformatf("v%0d trace_value", i), trace_id_value_o, vecs[i].tv);
        chk($sformatf("v%0d retire_valid", i), retire_valid_o, vecs[i].rv);
        if (vecs[i].rv) chk($sformatf("v%0d retire_id", i), retire_id_o, vecs[i].rid);
        chk($sformatf("v%0d inflight", i), inflight_cnt_o, vecs[i].inf);
        chk($sformatf("v%0d error", i), error_o, vecs[i].err);
      end
      $display("vec %0d: rst=%0d full=%0d req=%0d cv=%0d cval=%0d -> av=%0d id=%0d tp=%0d rv=%0d inf=%0d err=%0d",
               i, vecs[i].rst, vecs[i].full, vecs[i].req, vecs[i].cv, vecs[i].cval,
               alloc_valid_o, alloc_id_o, trace_id_push_o, retire_valid_o, inflight_cnt_o, error_o);
      step();
    end

    // Hand sequence: reset with 5 in flight and a commit pending.
    begin
      int wait_cnt;
      drive(1, 0, 0, 0, 0); step();
      drive(0, 0, 0, 0, 0);
      for (int c = 0; c < DEPTH; c++) step();
      drive(0, 0, 1, 0, 0);
      for (int c = 0; c < 5; c++) step();
      drive(1, 0, 0, 1, 0);
      #1;
      chk("pre-reset inflight", inflight_cnt_o, 5);
      chk("pre-reset pull", commit_id_pull_o, 1);
      step();
      drive(0, 0, 1, 1, 0);
      #1;
      chk("post-reset alloc_valid", alloc_valid_o, 0);
      chk("post-reset alloc_id", alloc_id_o, 0);
      chk("post-reset pull", commit_id_pull_o, 0);
      chk("post-reset trace_push", trace_id_push_o, 0);
      chk("post-reset trace_value", trace_id_value_o, 0);
      chk("post-reset retire_valid", retire_valid_o, 0);
      chk("post-reset retire_id", retire_id_o, 0);
      chk("post-reset inflight", inflight_cnt_o, 0);
      chk("post-reset error", error_o, 0);
      wait_cnt = 0;
      while (!alloc_valid_o && wait_cnt < 20) begin
        step();
        wait_cnt++;
      end
      chk("reinit latency", wait_cnt, DEPTH);
      chk("reinit first id", alloc_id_o, 0);
      $display("reset-seq: grant after %0d cycles id=%0d", wait_cnt, alloc_id_o);
    end

    // Random traffic against the reference model.
    drive(1, 0, 0, 0, 0); step();
    model_reset();
    begin
      int halt_age = 0;
      for (int n = 0; n < 1500; n++) begin
        bit r, f, q, cv, run, e_av, a, p, ok;
        int cval, id;
        r = ($urandom_range(0, 299) == 0) || (halted && halt_age > 4);
        f = ($urandom_range(0, 4) == 0);
        q = $urandom_range(0, 1) == 1;
        if (order_q.size() > 0) begin
          cv = $urandom_range(0, 1) == 1;
          cval = ($urandom_range(0, 99) == 0) ? int'($urandom_range(0, 7)) : order_q[0];
        end else begin
          cv = ($urandom_range(0, 99) == 0);
          cval = $urandom_range(0, 7);
        end
        drive(r, f, q, cv, cval);
        #1;
        run  = (init_left == 0) && !halted;
        e_av = run && (free_q.size() > 0) && !f;
        chk("rnd alloc_valid", alloc_valid_o, e_av);
        if (e_av) chk("rnd alloc_id", alloc_id_o, free_q[0]);
        chk("rnd pull", commit_id_pull_o, run && cv);
        chk("rnd trace_push", trace_id_push_o, m_tp);
        if (m_tp) chk("rnd trace_value", trace_id_value_o, m_tv);
        chk("rnd retire_valid", retire_valid_o, m_rv);
        if (m_rv) chk("rnd retire_id", retire_id_o, m_rid);
        chk("rnd inflight", inflight_cnt_o, order_q.size());
        chk("rnd error", error_o, m_err);
        if (r) begin
          model_reset();
          $display("rnd %0d: reset", n);
        end else begin
          a  = e_av && q;
          p  = run && cv;
          ok = p && (order_q.size() > 0) && (order_q[0] == cval);
          m_tp = a;
          m_rv = ok;
          if (a) begin
            id = free_q.pop_front();
            order_q.push_back(id);
            m_tv = id;
            $display("rnd %0d: alloc id=%0d", n, id);
          end
          if (ok) begin
            void'(order_q.pop_front());
            free_q.push_back(cval);
            m_rid = cval;
            $display("rnd %0d: retire id=%0d", n, cval);
          end else if (p) begin
            halted = 1;
            m_err  = 1;
            $display("rnd %0d: bad commit id=%0d -> halt", n, cval);
          end
          if (init_left > 0) begin
            free_q.push_back(DEPTH - init_left);
            init_left--;
          end
        end
        halt_age = halted ? halt_age + 1 : 0;
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reorder_id_manager.md
Name: reorder_id_manager

Overview:
- ID lifecycle manager for reorder_logic_top.
- Front end: owns the free pool of trace IDs. Hands a free ID to the upstream issuer and drives the trace_id_push/trace_id_value side of the reorder logic.
- Back end: sits on the commit side of the reorder logic. Pulls committed IDs, checks them against allocation order, and returns them to the free pool.

Parameters:
- DEPTH, 8: number of trace IDs and reorder entries; must be a power of two.
- ID_WIDTH, $clog2(DEPTH): ID width.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous reset, active high.
- reorder_full_i  in  1  reorder logic full (its full_o).
- alloc_valid_o  out  1  a free ID is offered on alloc_id_o.
- alloc_id_o  out  ID_WIDTH  offered ID (head of free list).
- alloc_req_i  in  1  issuer takes the offered ID; handshake completes when alloc_valid_o & alloc_req_i.
- trace_id_push_o  out  1  push of allocated ID into reorder logic.
- trace_id_value_o  out  ID_WIDTH  pushed ID.
- commit_id_valid_i  in  1  committed-ID queue non-empty.
- commit_id_value_i  in  ID_WIDTH  oldest committed ID.
- commit_id_pull_o  out  1  pull oldest committed ID.
- retire_valid_o  out  1  ID retired and returned to pool.
- retire_id_o  out  ID_WIDTH  retired ID.
- inflight_cnt_o  out  ID_WIDTH+1  IDs allocated and not yet retired.
- error_o  out  1  sticky protocol error.

Behaviour:
- Reset: clock is clk_i. rst_i is synchronous, active high. Every output registers to 0. Both FIFOs empty, allocated bitmap cleared, FSM to StateInit.
- A reset asserted mid-operation discards all in-flight state; no retire is reported.

FSM (StateInit / StateRun / StateHalt):
- StateInit:
  - Pushes IDs 0..DEPTH-1 into the free list, one per cycle, over DEPTH cycles.
  - Then moves to StateRun.
  - alloc_valid_o = 0 and commit_id_pull_o = 0 throughout.
- StateRun: normal operation.
- StateHalt:
  - Entered on any error; exited only by rst_i.
  - alloc_valid_o = 0, commit_id_pull_o = 0, error_o held at 1.

Allocation:
- alloc_valid_o = (StateRun) & free list non-empty & ~reorder_full_i. Combinational.
- On the alloc handshake:
  - pop the free list;
  - push the ID into the order FIFO;
  - set the allocated bit;
  - next cycle: trace_id_push_o = 1 and trace_id_value_o = the ID (1-cycle registered latency).
- trace_id_push_o is a single-cycle pulse per allocation.

Commit pull:
- commit_id_pull_o = (StateRun) & commit_id_valid_i. Combinational.
- On a pull, the ID is checked. The ID must equal the order FIFO head and its allocated bit must be set.
  - Check passes: pop the order FIFO, clear the allocated bit, push the ID to the free-list tail. Next cycle: retire_valid_o = 1 and retire_id_o = the ID.
  - Check fails: the ID is not freed. Next cycle: error_o = 1, FSM moves to StateHalt.
- A pull while the order FIFO is empty is an error.

Simultaneous events:
- Alloc and retire in the same cycle are both performed; inflight_cnt_o is unchanged.
- A retired ID is not bypassed to alloc_id_o in the same cycle. It becomes visible the next cycle at the earliest, so with an empty free list alloc_valid_o stays 0 for that cycle.

inflight_cnt_o:
- Registered; +1 per alloc, -1 per retire. Range 0..DEPTH.
- Free-list count + inflight = DEPTH at all times in StateRun.
- Both FIFOs are depth DEPTH with wrap-around pointers. Neither can overflow by construction. The free list is full exactly when inflight is 0.

Decomposition:
- Package reorder_pkg holds:
  - FSM state constants: StateInit, StateRun, StateHalt;
  - the ID-width helper.
- Sub-module reorder_id_fifo: synchronous FIFO, parameters DEPTH and WIDTH, with push/pull/valid/full/count. It is instantiated twice: free list and order FIFO.
- The top level holds the FSM, allocated bitmap, checks and output registers.

Test Plan:
1. Release rst_i, hold alloc_req_i = 1. alloc_valid_o stays 0 for 8 cycles, then IDs 0,1,…,7 are granted on consecutive cycles. trace_id_push_o follows each grant one cycle later. alloc_valid_o then drops; inflight_cnt_o = 8.
2. Allocate 0,1,2, then commit 0,1,2. retire_id_o = 0,1,2 one cycle after each pull; inflight_cnt_o returns to 0. Further allocations yield 3..7 then 0,1,2.
3. With inflight 4, an alloc handshake and a valid commit in the same cycle: inflight_cnt_o stays 4. trace_id_push_o and retire_valid_o both pulse the next cycle.
4. Allocate 0..2, then present commit_id_value_i = 2 (head is 0): error_o = 1 next cycle. commit_id_pull_o and alloc_valid_o stay 0 until rst_i.
5. reorder_full_i = 1 with 6 free IDs: alloc_valid_o = 0 and no trace_id_push_o. On deassertion, the grant resumes at the next free ID.
6. Assert rst_i with inflight 5 and a commit pending: the next cycle all outputs are 0. The 8-cycle init repeats and the first grant is ID 0.
